// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: requester indices, bus packet layout and default sizing.
// Consumers import this package with import cdb_arbiter_pkg::*.
package cdb_arbiter_pkg;

   localparam int NUM_CDB_REQ    = 4;
   localparam int ROB_DEPTH_BITS = 6;
   localparam int CDB_DATA_WIDTH = 32;
   localparam int CDB_SRC_BITS   = $clog2(NUM_CDB_REQ);

   typedef enum logic [CDB_SRC_BITS-1:0] {
      CDB_LD  = 2'd0,
      CDB_ALU = 2'd1,
      CDB_BR  = 2'd2,
      CDB_JR  = 2'd3
   } cdb_req_e;

   typedef struct packed {
      logic                      valid;
      logic [ROB_DEPTH_BITS-1:0] tag;
      logic [CDB_DATA_WIDTH-1:0] data;
      logic [CDB_SRC_BITS-1:0]   src;
   } cdb_pkt_t;

   // Modulo increment that also works when the requester count is not a power of two.
   function automatic int wrapInc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap.
// Shared by the CDB arbiter and the reservation-station issue select.
module rr_arbiter #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Scan from the pointer; j never exceeds 2N-2, so a single subtraction wraps it.
   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered result per cycle from the out-of-order units.
// Optional macro CDB_LOAD_PRIO_EN adds load-pipe priority with per-unit starvation counters.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = NUM_CDB_REQ,
   parameter int TAG_BITS     = ROB_DEPTH_BITS,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 8,
   localparam int SRC_BITS    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*TAG_BITS-1:0]    req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           cdb_stall,
   input  logic                           flush,
   output logic                           cdb_valid,
   output logic [TAG_BITS-1:0]            cdb_tag,
   output logic [DATA_WIDTH-1:0]          cdb_data,
   output logic [SRC_BITS-1:0]            cdb_src
);

   logic [SRC_BITS-1:0]   rrPtr_q, rrPtr_d;
   logic                  cdbValid_q, cdbValid_d;
   logic [TAG_BITS-1:0]   cdbTag_q, cdbTag_d;
   logic [DATA_WIDTH-1:0] cdbData_q, cdbData_d;
   logic [SRC_BITS-1:0]   cdbSrc_q, cdbSrc_d;

   logic [NUM_REQ-1:0]    rrGnt;
   logic [SRC_BITS-1:0]   rrIdx;
   logic                  rrAny;
   logic [NUM_REQ-1:0]    pickGnt;
   logic [SRC_BITS-1:0]   pickIdx;
   logic                  grantEn;
   logic                  grantAny;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req_i (req_valid),
      .ptr_i (rrPtr_q),
      .gnt_o (rrGnt),
      .idx_o (rrIdx),
      .any_o (rrAny)
   );

`ifdef CDB_LOAD_PRIO_EN
   localparam int CNT_BITS = $clog2(STARVE_LIMIT + 1);
   localparam int LD_IDX   = int'(CDB_LD);

   logic [CNT_BITS-1:0] starveCnt_q [NUM_REQ];
   logic [CNT_BITS-1:0] starveCnt_d [NUM_REQ];
   logic [NUM_REQ-1:0]  starved;
   logic [NUM_REQ-1:0]  stGnt;
   logic [SRC_BITS-1:0] stIdx;
   logic                stAny;

   // The load pipe never starves itself, so only the other units can raise a starvation claim.
   always_comb begin
      starved = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         starved[i] = (i != LD_IDX) && req_valid[i] &&
                      (starveCnt_q[i] == CNT_BITS'(STARVE_LIMIT));
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_starve (
      .req_i (starved),
      .ptr_i (rrPtr_q),
      .gnt_o (stGnt),
      .idx_o (stIdx),
      .any_o (stAny)
   );

   always_comb begin
      pickGnt = rrGnt;
      pickIdx = rrIdx;
      if (stAny) begin
         pickGnt = stGnt;
         pickIdx = stIdx;
      end else if (req_valid[LD_IDX]) begin
         pickGnt         = '0;
         pickGnt[LD_IDX] = 1'b1;
         pickIdx         = SRC_BITS'(LD_IDX);
      end
   end

   // Counters age only on cycles where the bus could actually have served the unit.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         starveCnt_d[i] = starveCnt_q[i];
         if (flush) begin
            starveCnt_d[i] = '0;
         end else if (!cdb_stall) begin
            if ((i == LD_IDX) || !req_valid[i] || req_ready[i]) begin
               starveCnt_d[i] = '0;
            end else if (starveCnt_q[i] != CNT_BITS'(STARVE_LIMIT)) begin
               starveCnt_d[i] = starveCnt_q[i] + CNT_BITS'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            starveCnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            starveCnt_q[i] <= starveCnt_d[i];
         end
      end
   end
`else
   always_comb begin
      pickGnt = rrGnt;
      pickIdx = rrIdx;
   end
`endif

   // Grants are suppressed in reset, on a downstream stall and on a flush.
   assign grantEn   = rst_n & ~flush & ~cdb_stall;
   assign req_ready = grantEn ? pickGnt : '0;
   assign grantAny  = |req_ready;

   always_comb begin
      rrPtr_d    = rrPtr_q;
      cdbValid_d = cdbValid_q;
      cdbTag_d   = cdbTag_q;
      cdbData_d  = cdbData_q;
      cdbSrc_d   = cdbSrc_q;
      if (flush) begin
         cdbValid_d = 1'b0;
      end else if (!cdb_stall) begin
         cdbValid_d = grantAny;
         if (grantAny) begin
            cdbTag_d  = req_tag[int'(pickIdx)*TAG_BITS +: TAG_BITS];
            cdbData_d = req_data[int'(pickIdx)*DATA_WIDTH +: DATA_WIDTH];
            cdbSrc_d  = pickIdx;
            rrPtr_d   = SRC_BITS'(wrapInc(int'(pickIdx), NUM_REQ));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrPtr_q    <= '0;
         cdbValid_q <= 1'b0;
         cdbTag_q   <= '0;
         cdbData_q  <= '0;
         cdbSrc_q   <= '0;
      end else begin
         rrPtr_q    <= rrPtr_d;
         cdbValid_q <= cdbValid_d;
         cdbTag_q   <= cdbTag_d;
         cdbData_q  <= cdbData_d;
         cdbSrc_q   <= cdbSrc_d;
      end
   end

   assign cdb_valid = cdbValid_q;
   assign cdb_tag   = cdbTag_q;
   assign cdb_data  = cdbData_q;
   assign cdb_src   = cdbSrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter against a queue-free behavioural model of the bus rules.
// The model follows CDB_LOAD_PRIO_EN when the macro is defined for the build.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TB = 6;
   localparam int DW = 32;
   localparam int SL = 4;
   localparam int SB = 2;
`ifdef CDB_LOAD_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*TB-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            cdb_stall;
   logic            flush;
   logic            cdb_valid;
   logic [TB-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [SB-1:0]   cdb_src;

   int testsRun  = 0;
   int failCount = 0;

   logic [N-1:0]  vIn;
   logic [TB-1:0] tIn [N];
   logic [DW-1:0] dIn [N];
   logic          stallIn;
   logic          flushIn;

   int            mPtr;
   bit            mValid;
   logic [TB-1:0] mTag;
   logic [DW-1:0] mData;
   int            mSrc;
   int            mCnt [N];

   cdb_arbiter #(
      .NUM_REQ      (N),
      .TAG_BITS     (TB),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (SL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .req_ready (req_ready),
      .cdb_stall (cdb_stall),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task applyStimulus();
      for (int i = 0; i < N; i++) begin
         req_tag[i*TB +: TB]  = tIn[i];
         req_data[i*DW +: DW] = dIn[i];
      end
      req_valid = vIn;
      cdb_stall = stallIn;
      flush     = flushIn;
   endtask

   task modelReset();
      mPtr   = 0;
      mValid = 1'b0;
      mTag   = '0;
      mData  = '0;
      mSrc   = 0;
      for (int i = 0; i < N; i++) mCnt[i] = 0;
   endtask

   // Winner according to the bus rules, or -1 when nothing may be granted.
   function automatic int modelPick();
      int j;
      if (!rst_n || flushIn || stallIn) return -1;
      if (PRIO) begin
         for (int k = 0; k < N; k++) begin
            j = (mPtr + k) % N;
            if (j != 0 && vIn[j] && mCnt[j] >= SL) return j;
         end
         if (vIn[0]) return 0;
      end
      for (int k = 0; k < N; k++) begin
         j = (mPtr + k) % N;
         if (vIn[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oneHot(input int g);
      logic [N-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task clockModel(input int g);
      @(posedge clk);
      if (flushIn) begin
         mValid = 1'b0;
         for (int i = 0; i < N; i++) mCnt[i] = 0;
      end else if (!stallIn) begin
         mValid = (g >= 0);
         if (g >= 0) begin
            mTag  = tIn[g];
            mData = dIn[g];
            mSrc  = g;
            mPtr  = (g + 1) % N;
         end
         for (int i = 1; i < N; i++) begin
            if (!vIn[i] || g == i) mCnt[i] = 0;
            else if (mCnt[i] < SL) mCnt[i]++;
         end
      end
      #1;
   endtask

   task setIdle();
      vIn     = '0;
      stallIn = 1'b0;
      flushIn = 1'b0;
      for (int i = 0; i < N; i++) begin
         tIn[i] = TB'($urandom);
         dIn[i] = $urandom;
      end
   endtask

   task test_reset();
      rst_n = 1'b0;
      setIdle();
      vIn = '1;
      applyStimulus();
      modelReset();
      #2;
      testsRun++;
      if (req_ready !== '0) begin
         failCount++;
         $display("[TB] FAIL reset_ready: got %b want 0000", req_ready);
      end
      @(posedge clk); #1;
      testsRun++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== '0) begin
         failCount++;
         $display("[TB] FAIL reset_outputs: got v=%b tag=%h data=%h src=%0d want all zero",
                  cdb_valid, cdb_tag, cdb_data, cdb_src);
      end
      @(negedge clk);
      rst_n = 1'b1;
      setIdle();
      applyStimulus();
   endtask

   task test_rotate();
      int g;
      setIdle();
      for (int c = 0; c < 9; c++) begin
         vIn = (c < 8) ? '1 : '0;
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL rotate_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && (cdb_src !== SB'(mSrc) || cdb_tag !== mTag || cdb_data !== mData))) begin
            failCount++;
            $display("[TB] FAIL rotate_bus c=%0d: got v=%b src=%0d tag=%h data=%h want v=%b src=%0d tag=%h data=%h",
                     c, cdb_valid, cdb_src, cdb_tag, cdb_data, mValid, mSrc, mTag, mData);
         end
         @(negedge clk);
      end
   endtask

   task test_single();
      int g;
      setIdle();
      for (int c = 0; c < 3; c++) begin
         vIn    = (c == 0) ? 4'b0100 : (c == 2) ? 4'b1111 : 4'b0000;
         tIn[2] = 6'd5;
         dIn[2] = 32'hDEADBEEF;
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL single_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && (cdb_src !== SB'(mSrc) || cdb_tag !== mTag || cdb_data !== mData))) begin
            failCount++;
            $display("[TB] FAIL single_bus c=%0d: got v=%b src=%0d tag=%h data=%h want v=%b src=%0d tag=%h data=%h",
                     c, cdb_valid, cdb_src, cdb_tag, cdb_data, mValid, mSrc, mTag, mData);
         end
         @(negedge clk);
      end
   endtask

   task test_stall();
      int g;
      setIdle();
      for (int c = 0; c < 6; c++) begin
         vIn     = (c == 0) ? 4'b0001 : (c < 5) ? 4'b0010 : 4'b0000;
         tIn[0]  = 6'd7;
         stallIn = (c >= 1 && c <= 3);
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL stall_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && (cdb_src !== SB'(mSrc) || cdb_tag !== mTag || cdb_data !== mData))) begin
            failCount++;
            $display("[TB] FAIL stall_bus c=%0d: got v=%b src=%0d tag=%h data=%h want v=%b src=%0d tag=%h data=%h",
                     c, cdb_valid, cdb_src, cdb_tag, cdb_data, mValid, mSrc, mTag, mData);
         end
         @(negedge clk);
      end
   endtask

   task test_flush_stall();
      int g;
      setIdle();
      for (int c = 0; c < 4; c++) begin
         vIn     = (c < 3) ? 4'b1111 : 4'b0000;
         stallIn = (c == 1);
         flushIn = (c == 1);
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL flush_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && (cdb_src !== SB'(mSrc) || cdb_tag !== mTag || cdb_data !== mData))) begin
            failCount++;
            $display("[TB] FAIL flush_bus c=%0d: got v=%b src=%0d tag=%h data=%h want v=%b src=%0d tag=%h data=%h",
                     c, cdb_valid, cdb_src, cdb_tag, cdb_data, mValid, mSrc, mTag, mData);
         end
         @(negedge clk);
      end
   endtask

   task test_async_reset();
      int g;
      setIdle();
      vIn = 4'b0110;
      applyStimulus();
      #1; g = modelPick();
      clockModel(g);
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++;
      if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0 || req_ready !== '0) begin
         failCount++;
         $display("[TB] FAIL async_reset: got v=%b tag=%h data=%h src=%0d ready=%b want all zero",
                  cdb_valid, cdb_tag, cdb_data, cdb_src, req_ready);
      end
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      vIn   = '1;
      applyStimulus();
      #1;
      testsRun++;
      if (req_ready !== 4'b0001) begin
         failCount++;
         $display("[TB] FAIL async_first_grant: got %b want 0001", req_ready);
      end
      g = modelPick();
      clockModel(g);
      testsRun++;
      if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== tIn[0] || cdb_data !== dIn[0]) begin
         failCount++;
         $display("[TB] FAIL async_first_bus: got v=%b src=%0d tag=%h want v=1 src=0 tag=%h",
                  cdb_valid, cdb_src, cdb_tag, tIn[0]);
      end
      @(negedge clk);
   endtask

   task test_prio();
      int g;
      setIdle();
      for (int c = 0; c < 8; c++) begin
         vIn = 4'b1001;
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL prio_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && cdb_src !== SB'(mSrc))) begin
            failCount++;
            $display("[TB] FAIL prio_bus c=%0d: got v=%b src=%0d want v=%b src=%0d",
                     c, cdb_valid, cdb_src, mValid, mSrc);
         end
         @(negedge clk);
      end
   endtask

   task test_random();
      int g;
      setIdle();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!vIn[i] && $urandom_range(9) < 4) begin
               vIn[i] = 1'b1;
               tIn[i] = TB'($urandom);
               dIn[i] = $urandom;
            end
         end
         stallIn = ($urandom_range(9) < 2);
         flushIn = ($urandom_range(19) == 0);
         applyStimulus();
         #1; g = modelPick();
         testsRun++;
         if (req_ready !== oneHot(g)) begin
            failCount++;
            $display("[TB] FAIL random_ready c=%0d: got %b want %b", c, req_ready, oneHot(g));
         end
         clockModel(g);
         testsRun++;
         if (cdb_valid !== mValid || (mValid && (cdb_src !== SB'(mSrc) || cdb_tag !== mTag || cdb_data !== mData))) begin
            failCount++;
            $display("[TB] FAIL random_bus c=%0d: got v=%b src=%0d tag=%h data=%h want v=%b src=%0d tag=%h data=%h",
                     c, cdb_valid, cdb_src, cdb_tag, cdb_data, mValid, mSrc, mTag, mData);
         end
         if (g >= 0) vIn[g] = 1'b0;
         if (flushIn) vIn = '0;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_rotate();
      test_single();
      test_stall();
      test_flush_stall();
      test_async_reset();
      test_prio();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
